// File: rtl/hvsync_if.sv
// Sync-decoder bus: incoming hsync/vsync pair and the recovered beam position,
// measured timing and lock status.
interface hvsync_if;
  logic       hsync_in;
  logic       vsync_in;
  logic [7:0] hpos;
  logic [6:0] vpos;
  logic       display_on;
  logic [8:0] h_total;
  logic [7:0] v_total;
  logic       locked;
  logic       frame_start;
  logic       sync_err;

  // master drives the sync pair and observes the decoder results
  modport master (
    output hsync_in,
    output vsync_in,
    input  hpos,
    input  vpos,
    input  display_on,
    input  h_total,
    input  v_total,
    input  locked,
    input  frame_start,
    input  sync_err
  );

  modport slave (
    input  hsync_in,
    input  vsync_in,
    output hpos,
    output vpos,
    output display_on,
    output h_total,
    output v_total,
    output locked,
    output frame_start,
    output sync_err
  );
endinterface

// File: rtl/hvsync_decoder.sv
// Recovers beam position from an incoming hsync/vsync pair, measures line and
// frame lengths, and tracks lock against the expected raster timing.
module hvsync_decoder #(
  parameter int H_DISPLAY   = 160,
  parameter int V_DISPLAY   = 120,
  parameter int H_TOTAL     = 161,
  parameter int V_TOTAL     = 121,
  parameter int LOCK_FRAMES = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  hvsync_if.slave  sync
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  function automatic logic [7:0] sat_inc_h(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [6:0] sat_inc_v(input logic [6:0] v);
    return (v == 7'h7F) ? v : v + 7'd1;
  endfunction

  logic          r_hsync_q;
  logic          r_vsync_q;
  logic [7:0]    r_hpos;
  logic [6:0]    r_vpos;
  logic [8:0]    r_h_total;
  logic [7:0]    r_v_total;
  logic          r_h_seen;
  logic          r_v_pending;
  logic          r_line_bad;
  logic          r_frame_start;
  logic          r_locked;
  logic          r_sync_err;
  state_t        r_state;
  logic [GW-1:0] r_good_cnt;

  state_t        w_state_nxt;
  logic [GW-1:0] w_good_nxt;
  logic          w_err_nxt;
  logic          w_h_edge;
  logic          w_v_edge;
  logic [8:0]    w_hpos_inc;
  logic [7:0]    w_vpos_inc;
  logic          w_frame_bnd;
  logic          w_line_len_bad;
  logic          w_line_bad_now;
  logic          w_vtot_ok;
  logic          w_v_missing;
  logic          w_hpos_sat;
  logic          w_good_last;

  assign w_h_edge       = sync.hsync_in & ~r_hsync_q;
  assign w_v_edge       = sync.vsync_in & ~r_vsync_q;
  assign w_hpos_inc     = {1'b0, r_hpos} + 9'd1;
  assign w_vpos_inc     = {1'b0, r_vpos} + 8'd1;
  // a vsync rising together with hsync still closes the frame on that edge
  assign w_frame_bnd    = w_h_edge & (r_v_pending | w_v_edge);
  assign w_line_len_bad = w_h_edge & (w_hpos_inc != 9'(H_TOTAL));
  assign w_line_bad_now = r_line_bad | (w_line_len_bad & r_h_seen);
  assign w_vtot_ok      = (w_vpos_inc == 8'(V_TOTAL));
  assign w_v_missing    = w_h_edge & ~(r_v_pending | w_v_edge) &
                          (r_vpos == 7'(V_TOTAL - 1));
  assign w_hpos_sat     = (r_hpos == 8'hFF);
  assign w_good_last    = (32'(r_good_cnt) + 32'd1) >= 32'(LOCK_FRAMES);

  // Stage: input sync sampling for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync_q <= 1'b1;
      r_vsync_q <= 1'b1;
    end else begin
      r_hsync_q <= sync.hsync_in;
      r_vsync_q <= sync.vsync_in;
    end
  end

  // Stage: horizontal position and line length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hpos    <= '0;
      r_h_total <= '0;
      r_h_seen  <= 1'b0;
    end else if (w_h_edge) begin
      r_hpos    <= '0;
      r_h_total <= w_hpos_inc;
      r_h_seen  <= 1'b1;
    end else begin
      r_hpos    <= sat_inc_h(r_hpos);
    end
  end

  // Stage: vertical position, frame length and per-frame line quality
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vpos        <= '0;
      r_v_total     <= '0;
      r_v_pending   <= 1'b0;
      r_line_bad    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_bnd;
      if (w_frame_bnd) begin
        r_vpos      <= '0;
        r_v_total   <= w_vpos_inc;
        r_v_pending <= 1'b0;
        r_line_bad  <= 1'b0;
      end else begin
        if (w_v_edge) begin
          r_v_pending <= 1'b1;
        end
        if (w_h_edge) begin
          r_vpos <= sat_inc_v(r_vpos);
        end
        if (w_line_len_bad && r_h_seen) begin
          r_line_bad <= 1'b1;
        end
      end
    end
  end

  // Stage: lock state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SEARCH;
      r_good_cnt <= '0;
      r_locked   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_locked   <= (w_state_nxt == LOCKED);
      r_sync_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_frame_bnd) begin
          w_state_nxt = VERIFY;
          w_good_nxt  = '0;
        end
      end
      VERIFY: begin
        if (w_frame_bnd) begin
          if (w_vtot_ok && !w_line_bad_now) begin
            w_good_nxt = r_good_cnt + 1'b1;
            if (w_good_last) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            w_state_nxt = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (w_line_len_bad || w_v_missing || (w_frame_bnd && !w_vtot_ok)) begin
          w_state_nxt = SEARCH;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
    // lost hsync overrides everything; only a loss of lock is reported
    if (w_hpos_sat) begin
      w_state_nxt = SEARCH;
      w_err_nxt   = (r_state == LOCKED);
    end
  end

  assign sync.hpos        = r_hpos;
  assign sync.vpos        = r_vpos;
  assign sync.h_total     = r_h_total;
  assign sync.v_total     = r_v_total;
  assign sync.locked      = r_locked;
  assign sync.frame_start = r_frame_start;
  assign sync.sync_err    = r_sync_err;
  assign sync.display_on  = r_locked &
                            ({1'b0, r_hpos} < 9'(H_DISPLAY)) &
                            ({1'b0, r_vpos} < 8'(V_DISPLAY));

endmodule

// File: tb/tb_hvsync_decoder.sv
// Directed bench for hvsync_decoder on a reduced 24x12 raster (20x10 visible)
// so that several full frames fit in a short run.
module tb_hvsync_decoder;

  localparam int HT = 24;
  localparam int VT = 12;
  localparam int HD = 20;
  localparam int VD = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hvsync_if sif ();

  hvsync_decoder #(
    .H_DISPLAY  (HD),
    .V_DISPLAY  (VD),
    .H_TOTAL    (HT),
    .V_TOTAL    (VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sync   (sif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit omit_vs = 1'b0;

  // event counters sampled on the falling edge
  int fs_cnt = 0;
  int err_cnt = 0;
  int don_run = 0;
  int last_frame_don = 0;
  always @(negedge clk) begin
    if (sif.frame_start) begin
      fs_cnt         <= fs_cnt + 1;
      last_frame_don <= don_run;
      don_run        <= int'(sif.display_on);
    end else begin
      don_run <= don_run + int'(sif.display_on);
    end
    if (sif.sync_err) err_cnt <= err_cnt + 1;
  end

  task automatic drive_cycle(input logic hs, input logic vs);
    @(negedge clk);
    #1;
    sif.hsync_in = hs;
    sif.vsync_in = vs;
  endtask

  task automatic drive_line(input int len, input logic vs, input int c0);
    for (int c = c0; c < len; c++) drive_cycle(c < 2, vs && (c >= 4));
  endtask

  task automatic drive_lines(input int l_from, input int l_to, input int c0);
    for (int l = l_from; l <= l_to; l++)
      drive_line(HT, (l == VT - 1) && !omit_vs, (l == l_from) ? c0 : 0);
  endtask

  task automatic test_reset;
    sif.hsync_in = 1'b0;
    sif.vsync_in = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (sif.hpos !== 8'd0) begin n_bad++; $display("FAIL reset_hpos: got %0d want 0", sif.hpos); end
    n_cmp++; if (sif.vpos !== 7'd0) begin n_bad++; $display("FAIL reset_vpos: got %0d want 0", sif.vpos); end
    n_cmp++; if ({sif.h_total, sif.v_total} !== 17'd0) begin n_bad++; $display("FAIL reset_totals: got %0d/%0d want 0/0", sif.h_total, sif.v_total); end
    n_cmp++; if ({sif.locked, sif.frame_start, sif.sync_err, sif.display_on} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {sif.locked, sif.frame_start, sif.sync_err, sif.display_on}); end
    reset_n = 1'b1;
  endtask

  task automatic test_nominal;
    drive_lines(0, VT - 1, 0);
    drive_lines(0, VT - 1, 0);
    drive_lines(0, VT - 1, 0);
    n_cmp++; if (sif.locked !== 1'b0) begin n_bad++; $display("FAIL nom_prelock: locked=%b want 0", sif.locked); end
    n_cmp++; if (sif.h_total !== 9'd24) begin n_bad++; $display("FAIL nom_h_total: got %0d want 24", sif.h_total); end
    n_cmp++; if (sif.v_total !== 8'd12) begin n_bad++; $display("FAIL nom_v_total: got %0d want 12", sif.v_total); end
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_cmp++; if (sif.locked !== 1'b1) begin n_bad++; $display("FAIL nom_lock_3rd: locked=%b want 1", sif.locked); end
    n_cmp++; if ({sif.frame_start, sif.hpos, sif.vpos} !== {1'b1, 8'd0, 7'd0}) begin n_bad++; $display("FAIL nom_frame_start: fs=%b hpos=%0d vpos=%0d want 1/0/0", sif.frame_start, sif.hpos, sif.vpos); end
    n_cmp++; if (sif.display_on !== 1'b1) begin n_bad++; $display("FAIL nom_display_on0: got %b want 1", sif.display_on); end
    drive_line(HT, 1'b0, 2);
    drive_lines(1, VT - 1, 0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_cmp++; if (last_frame_don !== HD * VD) begin n_bad++; $display("FAIL nom_display_count: got %0d want %0d", last_frame_don, HD * VD); end
    n_cmp++; if (fs_cnt !== 4) begin n_bad++; $display("FAIL nom_frame_starts: got %0d want 4", fs_cnt); end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL nom_no_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_line_cut;
    int e0;
    e0 = err_cnt;
    drive_line(HT, 1'b0, 2);
    drive_lines(1, 4, 0);
    drive_line(14, 1'b0, 0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_cmp++; if (sif.sync_err !== 1'b1) begin n_bad++; $display("FAIL cut_sync_err: got %b want 1", sif.sync_err); end
    n_cmp++; if (sif.locked !== 1'b0) begin n_bad++; $display("FAIL cut_unlock: locked=%b want 0", sif.locked); end
    n_cmp++; if (sif.h_total !== 9'd14) begin n_bad++; $display("FAIL cut_h_total: got %0d want 14", sif.h_total); end
    drive_cycle(1'b0, 1'b0);
    n_cmp++; if (sif.sync_err !== 1'b0) begin n_bad++; $display("FAIL cut_err_width: got %b want 0", sif.sync_err); end
    drive_line(HT, 1'b0, 3);
    drive_lines(7, VT - 1, 0);
    drive_lines(0, VT - 1, 0);
    drive_lines(0, VT - 1, 0);
    n_cmp++; if (sif.locked !== 1'b0) begin n_bad++; $display("FAIL cut_relock_early: locked=%b want 0", sif.locked); end
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_cmp++; if (sif.locked !== 1'b1) begin n_bad++; $display("FAIL cut_relock: locked=%b want 1", sif.locked); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL cut_err_count: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_hsync_lost;
    int e0;
    e0 = err_cnt;
    drive_line(HT, 1'b0, 2);
    repeat (300) drive_cycle(1'b0, 1'b0);
    n_cmp++; if (sif.hpos !== 8'd255) begin n_bad++; $display("FAIL lost_hpos_sat: got %0d want 255", sif.hpos); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL lost_err_count: got %0d want 1", err_cnt - e0); end
    n_cmp++; if ({sif.locked, sif.display_on} !== 2'b00) begin n_bad++; $display("FAIL lost_flags: locked/display_on=%b want 00", {sif.locked, sif.display_on}); end
    drive_cycle(1'b0, 1'b0);
    n_cmp++; if (sif.hpos !== 8'd255) begin n_bad++; $display("FAIL lost_hpos_hold: got %0d want 255", sif.hpos); end
  endtask

  task automatic test_missing_vsync;
    int e0;
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_cmp++; if (sif.h_total !== 9'd256) begin n_bad++; $display("FAIL mv_h_total_256: got %0d want 256", sif.h_total); end
    drive_line(HT, 1'b0, 2);
    drive_lines(1, VT - 1, 0);
    drive_lines(0, VT - 1, 0);
    drive_lines(0, VT - 1, 0);
    omit_vs = 1'b1;
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_cmp++; if (sif.locked !== 1'b1) begin n_bad++; $display("FAIL mv_locked_before: locked=%b want 1", sif.locked); end
    e0 = err_cnt;
    drive_line(HT, 1'b0, 2);
    drive_lines(1, VT - 1, 0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_cmp++; if ({sif.sync_err, sif.locked} !== 2'b10) begin n_bad++; $display("FAIL mv_err: sync_err/locked=%b want 10", {sif.sync_err, sif.locked}); end
    n_cmp++; if (sif.vpos !== 7'd12) begin n_bad++; $display("FAIL mv_vpos_past: got %0d want 12", sif.vpos); end
    drive_line(HT, 1'b0, 2);
    repeat (10) drive_lines(0, VT - 1, 0);
    n_cmp++; if (sif.vpos !== 7'd127) begin n_bad++; $display("FAIL mv_vpos_sat: got %0d want 127", sif.vpos); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL mv_err_count: got %0d want 1", err_cnt - e0); end
    omit_vs = 1'b0;
  endtask

  task automatic test_simultaneous;
    int f0;
    f0 = fs_cnt;
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1);
    n_cmp++; if ({sif.hpos, sif.vpos} !== {8'd0, 7'd0}) begin n_bad++; $display("FAIL sim_pos: hpos=%0d vpos=%0d want 0/0", sif.hpos, sif.vpos); end
    n_cmp++; if (sif.frame_start !== 1'b1) begin n_bad++; $display("FAIL sim_frame_start: got %b want 1", sif.frame_start); end
    n_cmp++; if (sif.v_total !== 8'd128) begin n_bad++; $display("FAIL sim_v_total: got %0d want 128", sif.v_total); end
    drive_cycle(1'b0, 1'b0);
    n_cmp++; if (sif.frame_start !== 1'b0) begin n_bad++; $display("FAIL sim_fs_width: got %b want 0", sif.frame_start); end
    drive_line(HT, 1'b0, 3);
    n_cmp++; if (fs_cnt - f0 !== 1) begin n_bad++; $display("FAIL sim_fs_count: got %0d want 1", fs_cnt - f0); end
  endtask

  task automatic test_reset_midframe;
    drive_lines(0, 5, 0);
    drive_cycle(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({sif.hpos, sif.vpos, sif.h_total, sif.v_total} !== 32'd0) begin n_bad++; $display("FAIL rst_async_counts: hpos=%0d vpos=%0d h_total=%0d v_total=%0d want 0", sif.hpos, sif.vpos, sif.h_total, sif.v_total); end
    n_cmp++; if ({sif.locked, sif.frame_start, sif.sync_err, sif.display_on} !== 4'b0000) begin n_bad++; $display("FAIL rst_async_flags: got %b want 0000", {sif.locked, sif.frame_start, sif.sync_err, sif.display_on}); end
    repeat (3) drive_cycle(1'b1, 1'b0);
    reset_n = 1'b1;
    repeat (3) drive_cycle(1'b1, 1'b0);
    n_cmp++; if (sif.hpos !== 8'd3) begin n_bad++; $display("FAIL rst_no_edge_hpos: got %0d want 3", sif.hpos); end
    n_cmp++; if (sif.h_total !== 9'd0) begin n_bad++; $display("FAIL rst_no_edge_h_total: got %0d want 0", sif.h_total); end
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_cmp++; if ({sif.hpos, sif.h_total} !== {8'd0, 9'd6}) begin n_bad++; $display("FAIL rst_first_edge: hpos=%0d h_total=%0d want 0/6", sif.hpos, sif.h_total); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_line_cut();
    test_hsync_lost();
    test_missing_vsync();
    test_simultaneous();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
